// File: rtl/partial_buffer_if.sv
// Bus bundle for partial_buffer: staging write, commit (pop) and column read.
// The buffer side takes the slave modport; the driver takes master.
interface partial_buffer_if #(
  parameter int AW = 10,
  parameter int DW = 12,
  parameter int N  = 3
) ();
  logic          wen;
  logic          pop;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic [DW*N-1:0] rdata;

  modport master (
    output wen, pop, waddr, wdata, raddr,
    input  rdata
  );

  modport slave (
    input  wen, pop, waddr, wdata, raddr,
    output rdata
  );
endinterface

// File: rtl/partial_buffer.sv
// Line buffer: one staging line plus N committed lines; a pop shifts every line
// down by one in a single edge and the read port returns a whole column.
module partial_buffer #(
  parameter int AW = 10,
  parameter int DW = 12,
  parameter int N  = 3,
  parameter int HW = 640
) (
  input  logic           clk,
  input  logic           rst,
  partial_buffer_if.slave bus
);

  localparam logic [AW:0] HW_L = (AW+1)'(HW);

  logic            wr_ok;
  logic            rd_ok;
  logic [DW*N-1:0] rdata_bus;

  assign wr_ok = bus.wen && ({1'b0, bus.waddr} < HW_L);
  assign rd_ok = {1'b0, bus.raddr} < HW_L;

  logic [DW-1:0] stage_reg [HW];

  // Staging is never cleared by pop, so uncommitted columns carry over.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < HW; c++) stage_reg[c] <= '0;
    end else if (wr_ok) begin
      stage_reg[bus.waddr] <= bus.wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_line
      logic [DW-1:0] mem_reg [HW];
      logic [DW-1:0] field_reg;

      if (gi == 0) begin : g_newest
        // A write landing on the pop edge is folded into the committed line.
        always_ff @(posedge clk) begin
          if (!rst) begin
            for (int c = 0; c < HW; c++) mem_reg[c] <= '0;
          end else if (bus.pop) begin
            for (int c = 0; c < HW; c++) mem_reg[c] <= stage_reg[c];
            if (wr_ok) mem_reg[bus.waddr] <= bus.wdata;
          end
        end
      end else begin : g_older
        always_ff @(posedge clk) begin
          if (!rst) begin
            for (int c = 0; c < HW; c++) mem_reg[c] <= '0;
          end else if (bus.pop) begin
            for (int c = 0; c < HW; c++) mem_reg[c] <= g_line[gi-1].mem_reg[c];
          end
        end
      end

      // Read sees the committed contents from before any pop on this edge.
      always_ff @(posedge clk) begin
        if (!rst) begin
          field_reg <= '0;
        end else if (rd_ok) begin
          field_reg <= mem_reg[bus.raddr];
        end else begin
          field_reg <= '0;
        end
      end

      assign rdata_bus[gi*DW +: DW] = field_reg;
    end
  endgenerate

  assign bus.rdata = rdata_bus;

endmodule

// File: tb/tb_partial_buffer.sv
// Directed scoreboard bench for partial_buffer: expected columns are queued
// when a read is issued and compared one edge later.
module tb_partial_buffer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   rd_valid = 1'b0;

  logic [35:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  partial_buffer_if #(.AW(10), .DW(12), .N(3)) bus ();

  partial_buffer #(.AW(10), .DW(12), .N(3), .HW(640)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_next();
    logic [35:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (bus.rdata === e) else begin
      errors++;
      $error("FAIL %s: rdata=%h expected %h", t, bus.rdata, e);
    end
    $display("read %s: rdata=%h expected %h", t, bus.rdata, e);
  endtask

  task automatic tick();
    bit had;
    had = rd_valid;
    @(posedge clk);
    #1;
    if (had) check_next();
  endtask

  task automatic rd(input logic [9:0] a, input logic [35:0] e, input string t);
    bus.raddr = a;
    rd_valid  = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    rd_valid  = 1'b0;
  endtask

  task automatic check_zero(input string t);
    checks++;
    assert (bus.rdata === 36'h0) else begin
      errors++;
      $error("FAIL %s: rdata=%h expected %h", t, bus.rdata, 36'h0);
    end
    $display("direct %s: rdata=%h expected 0", t, bus.rdata);
  endtask

  initial begin
    rst       = 1'b0;
    bus.wen   = 1'b0;
    bus.pop   = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr = '0;

    // Reset held for 5 cycles
    repeat (5) tick();
    check_zero("reset_rdata");
    rst = 1'b1;
    rd(10'd0,   36'h0, "reset_col0");
    rd(10'd639, 36'h0, "reset_col639");

    // Single line with pop on the last column
    for (int c = 0; c < 640; c++) begin
      bus.wen = 1'b1; bus.waddr = 10'(c); bus.wdata = 12'(c); bus.pop = (c == 639);
      tick();
    end
    bus.wen = 1'b0; bus.pop = 1'b0;
    rd(10'd5,   {12'h000, 12'h000, 12'h005}, "single_col5");
    rd(10'd639, {12'h000, 12'h000, 12'h27F}, "single_col639");

    // Six streamed lines: line k (1-based) column c holds (k-1)*640+c
    for (int i = 0; i < 3840; i++) begin
      bus.wen = 1'b1; bus.waddr = 10'(i % 640); bus.wdata = 12'(i); bus.pop = ((i % 640) == 639);
      tick();
    end
    bus.wen = 1'b0; bus.pop = 1'b0;
    rd(10'd10,  {12'h78A, 12'hA0A, 12'hC8A}, "stream_col10");
    rd(10'd639, {12'h9FF, 12'hC7F, 12'hEFF}, "stream_col639");

    // Back-to-back reads, no gaps
    rd(10'd0, {12'h780, 12'hA00, 12'hC80}, "latency_col0");
    rd(10'd1, {12'h781, 12'hA01, 12'hC81}, "latency_col1");
    rd(10'd2, {12'h782, 12'hA02, 12'hC82}, "latency_col2");

    // Stage without commit: committed column unchanged
    bus.wen = 1'b1; bus.waddr = 10'd3; bus.wdata = 12'hFFF;
    rd(10'd3, {12'h783, 12'hA03, 12'hC83}, "stage_same_cycle");
    bus.wen = 1'b0;
    rd(10'd3, {12'h783, 12'hA03, 12'hC83}, "stage_no_pop");

    // Read on the pop edge still returns pre-pop contents
    bus.pop = 1'b1;
    rd(10'd3, {12'h783, 12'hA03, 12'hC83}, "read_on_pop_edge");
    bus.pop = 1'b0;
    rd(10'd3, {12'hA03, 12'hC83, 12'hFFF}, "pop_col3");
    rd(10'd4, {12'hA04, 12'hC84, 12'hC84}, "pop_keeps_stage_col4");

    // Write and pop together: pixel is part of the commit
    bus.wen = 1'b1; bus.pop = 1'b1; bus.waddr = 10'd7; bus.wdata = 12'h123;
    tick();
    bus.wen = 1'b0; bus.pop = 1'b0;
    rd(10'd7, {12'hC87, 12'hC87, 12'h123}, "wen_pop_col7");

    // Out-of-range write ignored while pop still shifts
    bus.wen = 1'b1; bus.pop = 1'b1; bus.waddr = 10'd700; bus.wdata = 12'h5A5;
    tick();
    bus.wen = 1'b0; bus.pop = 1'b0;
    rd(10'd700, 36'h0,                        "oob_read700");
    rd(10'd7,   {12'hC87, 12'h123, 12'h123}, "oob_pop_col7");
    rd(10'd188, {12'hD3C, 12'hD3C, 12'hD3C}, "oob_no_alias188");
    rd(10'd60,  {12'hCBC, 12'hCBC, 12'hCBC}, "oob_no_alias60");

    // Reset in the middle of staging a line; wen/pop ignored during reset
    for (int c = 0; c <= 320; c++) begin
      bus.wen = 1'b1; bus.waddr = 10'(c); bus.wdata = 12'h800 | 12'(c);
      tick();
    end
    bus.raddr = 10'd7;
    tick();
    rst = 1'b0; bus.pop = 1'b1;
    tick();
    check_zero("midline_reset_rdata");
    rst = 1'b1; bus.wen = 1'b0; bus.pop = 1'b0;
    rd(10'd0,   36'h0, "post_reset_col0");
    rd(10'd320, 36'h0, "post_reset_col320");
    rd(10'd639, 36'h0, "post_reset_col639");
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    rd(10'd100, 36'h0, "discarded_stage_col100");

    // Fresh full line after reset
    for (int c = 0; c < 640; c++) begin
      bus.wen = 1'b1; bus.waddr = 10'(c); bus.wdata = 12'hF00 ^ 12'(c); bus.pop = (c == 639);
      tick();
    end
    bus.wen = 1'b0; bus.pop = 1'b0;
    rd(10'd0,   {12'h000, 12'h000, 12'hF00}, "fresh_col0");
    rd(10'd320, {12'h000, 12'h000, 12'hE40}, "fresh_col320");
    rd(10'd639, {12'h000, 12'h000, 12'hD7F}, "fresh_col639");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
